// File: rtl/xsz_pkg.sv
// Shared types and helpers for the xsz_pack coalescing buffer.
package xsz_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        OUT   = 2'd2
    } xsz_pack_st_e;

    // Lane merge for one byte: take the incoming byte only where its strobe is set.
    function automatic logic [7:0] bytemerge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       stb);
        return stb ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/xsz_pack_tmo.sv
// Idle timeout for a partially filled entry; hit requests a flush.
module xsz_pack_tmo #(
    parameter int TO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam int CW    = (TO > 0) ? $clog2(TO + 1) : 1;
    localparam int TO_M1 = (TO > 0) ? TO - 1 : 0;
    localparam bit ENABLED = (TO > 0);

    logic [CW-1:0] cnt;

    // Counts idle cycles spent accumulating; any accept restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = ENABLED && en && !clr && (cnt == TO_M1[CW-1:0]);

endmodule

// File: rtl/xsz_pack.sv
// Coalesces consecutive sparse lane-placed beats that hit the same wide word
// into one dense beat, with a single registered entry between s_* and m_*.
module xsz_pack
    import xsz_pkg::*;
#(
    parameter int DO = 64,
    parameter int A  = 19,
    parameter int SB = 8,
    parameter int TO = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_vld,
    output logic            s_rdy,
    input  logic [DO-1:0]   s_dat,
    input  logic [DO/8-1:0] s_stb,
    input  logic [A-1:0]    s_adr,
    input  logic [SB-1:0]   s_sb,
    input  logic            s_lst,
    output logic            m_vld,
    input  logic            m_rdy,
    output logic [DO-1:0]   m_dat,
    output logic [DO/8-1:0] m_stb,
    output logic [A-1:0]    m_adr,
    output logic [SB-1:0]   m_sb,
    output logic            m_lst
);

    localparam int SO = DO / 8;
    localparam int W  = $clog2(SO);

    xsz_pack_st_e state, state_nxt;

    logic [DO-1:0] e_dat, nxt_dat, merged_dat;
    logic [SO-1:0] e_stb, nxt_stb;
    logic [A-1:0]  e_adr, nxt_adr;
    logic [SB-1:0] e_sb, nxt_sb;
    logic          e_lst, nxt_lst;
    logic          merge_ok, accept, load, close, tmo_hit;

    assign merge_ok = (state == ACC)
                   && (s_adr[A-1:W] == e_adr[A-1:W])
                   && (s_sb == e_sb)
                   && ((s_stb & e_stb) == '0)
                   && !e_lst;

    assign s_rdy  = (state == EMPTY) || merge_ok || ((state == OUT) && m_rdy);
    assign accept = s_vld && s_rdy;
    assign load   = accept && (state != ACC);

    for (genvar i = 0; i < SO; i++) begin : g_lane
        assign merged_dat[8*i +: 8] = bytemerge(e_dat[8*i +: 8], s_dat[8*i +: 8], s_stb[i]);
    end

    // Candidate entry after this cycle's accept; only committed when accept is high.
    always_comb begin
        nxt_dat = merged_dat;
        nxt_stb = e_stb | s_stb;
        nxt_adr = e_adr;
        nxt_sb  = e_sb;
        nxt_lst = e_lst | s_lst;
        if (load) begin
            nxt_dat = s_dat;
            nxt_stb = s_stb;
            nxt_adr = {s_adr[A-1:W], {W{1'b0}}};
            nxt_sb  = s_sb;
            nxt_lst = s_lst;
        end
    end

    assign close = (&nxt_stb) || nxt_lst;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = close ? OUT : ACC;
            ACC: begin
                if (accept)              state_nxt = close ? OUT : ACC;
                else if (s_vld || tmo_hit) state_nxt = OUT;
            end
            OUT: begin
                if (m_rdy) begin
                    if (accept) state_nxt = close ? OUT : ACC;
                    else        state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            e_dat <= '0;
            e_stb <= '0;
            e_adr <= '0;
            e_sb  <= '0;
            e_lst <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                e_dat <= nxt_dat;
                e_stb <= nxt_stb;
                e_adr <= nxt_adr;
                e_sb  <= nxt_sb;
                e_lst <= nxt_lst;
            end
        end
    end

    xsz_pack_tmo #(.TO(TO)) u_tmo (
        .clk (clk),
        .rst (rst),
        .en  (state == ACC),
        .clr (accept),
        .hit (tmo_hit)
    );

    assign m_vld = (state == OUT);
    assign m_dat = e_dat;
    assign m_stb = e_stb;
    assign m_adr = e_adr;
    assign m_sb  = e_sb;
    assign m_lst = e_lst;

endmodule

// File: tb/tb_xsz_pack.sv
// Bench for xsz_pack: directed scenarios plus randomized beats against a word-level coalescing model.
module tb_xsz_pack;

    localparam int DO = 64;
    localparam int A  = 19;
    localparam int SB = 8;

    typedef struct {
        logic [DO-1:0]   dat;
        logic [DO/8-1:0] stb;
        logic [A-1:0]    adr;
        logic [SB-1:0]   sb;
        logic            lst;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_vld, m_rdy, s_lst;
    logic [DO-1:0]   s_dat;
    logic [DO/8-1:0] s_stb;
    logic [A-1:0]    s_adr;
    logic [SB-1:0]   s_sb;

    logic            s_rdy, m_vld, m_lst;
    logic [DO-1:0]   m_dat;
    logic [DO/8-1:0] m_stb;
    logic [A-1:0]    m_adr;
    logic [SB-1:0]   m_sb;

    logic            z_s_rdy, z_m_vld, z_m_lst;
    logic [DO-1:0]   z_m_dat;
    logic [DO/8-1:0] z_m_stb;
    logic [A-1:0]    z_m_adr;
    logic [SB-1:0]   z_m_sb;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    xsz_pack #(.DO(DO), .A(A), .SB(SB), .TO(16)) dut (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_dat(s_dat), .s_stb(s_stb),
        .s_adr(s_adr), .s_sb(s_sb), .s_lst(s_lst),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_dat(m_dat), .m_stb(m_stb),
        .m_adr(m_adr), .m_sb(m_sb), .m_lst(m_lst)
    );

    // Same stimulus, timeout disabled.
    xsz_pack #(.DO(DO), .A(A), .SB(SB), .TO(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_rdy(z_s_rdy), .s_dat(s_dat), .s_stb(s_stb),
        .s_adr(s_adr), .s_sb(s_sb), .s_lst(s_lst),
        .m_vld(z_m_vld), .m_rdy(m_rdy), .m_dat(z_m_dat), .m_stb(z_m_stb),
        .m_adr(z_m_adr), .m_sb(z_m_sb), .m_lst(z_m_lst)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [DO-1:0] d, input logic [7:0] st,
                           input logic [A-1:0] ad, input logic [SB-1:0] sb, input logic l);
        s_vld = 1'b1;
        s_dat = d;
        s_stb = st;
        s_adr = ad;
        s_sb  = sb;
        s_lst = l;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [DO-1:0] d, input logic [7:0] st,
                             input logic [A-1:0] ad, input logic [SB-1:0] sb, input logic l);
        bit ok = 1'b0;
        present(d, st, ad, sb, l);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_rdy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        s_vld = 1'b0;
        if (!ok) begin
            checks++;
            $display("[TB] FAIL send_beat: s_rdy never rose for adr %h, got 0 required 1", ad);
        end
    endtask

    task automatic wait_mvld(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (m_vld) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (m_vld !== 1'b0 || s_rdy !== 1'b1) $display("[TB] FAIL reset_hs: got m_vld=%b s_rdy=%b required 0/1", m_vld, s_rdy);
        else passes++;
        checks++;
        if ({m_dat, m_stb, m_adr, m_sb, m_lst} !== '0)
            $display("[TB] FAIL reset_fields: got dat=%h stb=%h adr=%h sb=%h lst=%b required all zero", m_dat, m_stb, m_adr, m_sb, m_lst);
        else passes++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_four_beats();
        logic [DO-1:0] d[4];
        logic [7:0]    st[4];
        logic [DO-1:0] expd;
        st[0] = 8'h03; st[1] = 8'h0C; st[2] = 8'h30; st[3] = 8'hC0;
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) expd[8*i +: 8] = d[i/2][8*i +: 8];
        for (int k = 0; k < 3; k++) send_beat(d[k], st[k], 19'h100 + 19'(2*k), 8'h11, 1'b0);
        checks++;
        if (m_vld !== 1'b0) $display("[TB] FAIL four_early: got m_vld=%b required 0", m_vld);
        else passes++;
        send_beat(d[3], st[3], 19'h106, 8'h11, 1'b0);
        checks++;
        if (m_vld !== 1'b1 || m_adr !== 19'h100 || m_stb !== 8'hFF || m_lst !== 1'b0)
            $display("[TB] FAIL four_hdr: got vld=%b adr=%h stb=%h lst=%b required 1/00100/ff/0", m_vld, m_adr, m_stb, m_lst);
        else passes++;
        checks++;
        if (m_dat !== expd) $display("[TB] FAIL four_dat: got %h required %h", m_dat, expd);
        else passes++;
        step();
        checks++;
        if (m_vld !== 1'b0) $display("[TB] FAIL four_once: got m_vld=%b required 0", m_vld);
        else passes++;
    endtask

    task automatic test_addr_change();
        logic [DO-1:0] da, db;
        bit seen;
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        present(da, 8'h03, 19'h100, 8'h11, 1'b0);
        step();
        present(db, 8'h03, 19'h108, 8'h11, 1'b0);
        @(negedge clk);
        checks++;
        if (s_rdy !== 1'b0 || m_vld !== 1'b0) $display("[TB] FAIL addr_stall: got s_rdy=%b m_vld=%b required 0/0", s_rdy, m_vld);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (m_vld !== 1'b1 || m_stb !== 8'h03 || m_adr !== 19'h100 || m_dat[15:0] !== da[15:0] || s_rdy !== 1'b1)
            $display("[TB] FAIL addr_first: got vld=%b stb=%h adr=%h dat=%h s_rdy=%b required 1/03/00100/%h/1",
                     m_vld, m_stb, m_adr, m_dat[15:0], s_rdy, da[15:0]);
        else passes++;
        step();
        s_vld = 1'b0;
        wait_mvld(seen);
        checks++;
        if (!seen || m_adr !== 19'h108 || m_stb !== 8'h03 || m_dat !== db)
            $display("[TB] FAIL addr_second: got seen=%b adr=%h stb=%h required 1/00108/03", seen, m_adr, m_stb);
        else passes++;
        step();
    endtask

    task automatic test_overlap();
        logic [DO-1:0] da, db;
        bit seen, extra;
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        present(da, 8'h0F, 19'h100, 8'h22, 1'b0);
        step();
        present(db, 8'h0C, 19'h100, 8'h22, 1'b0);
        @(negedge clk);
        checks++;
        if (s_rdy !== 1'b0) $display("[TB] FAIL ovl_stall: got s_rdy=%b required 0", s_rdy);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (m_vld !== 1'b1 || m_stb !== 8'h0F || m_dat[31:0] !== da[31:0])
            $display("[TB] FAIL ovl_first: got vld=%b stb=%h dat=%h required 1/0f/%h", m_vld, m_stb, m_dat[31:0], da[31:0]);
        else passes++;
        step();
        s_vld = 1'b0;
        wait_mvld(seen);
        checks++;
        if (!seen || m_stb !== 8'h0C || m_dat !== db || m_adr !== 19'h100)
            $display("[TB] FAIL ovl_second: got seen=%b stb=%h dat=%h required 1/0c/%h", seen, m_stb, m_dat, db);
        else passes++;
        step();
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_vld) extra = 1'b1;
            step();
        end
        checks++;
        if (extra !== 1'b0) $display("[TB] FAIL ovl_count: got extra beat=%b required 0", extra);
        else passes++;
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        send_beat({$urandom, $urandom}, 8'h03, 19'h200, 8'h11, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (m_vld) early = 1'b1;
            step();
        end
        @(negedge clk);
        checks++;
        if (early !== 1'b0 || m_vld !== 1'b1 || m_stb !== 8'h03)
            $display("[TB] FAIL tmo_16: got early=%b m_vld=%b stb=%h required 0/1/03", early, m_vld, m_stb);
        else passes++;
        step();
    endtask

    task automatic test_timeout_disabled();
        logic [DO-1:0] d1, d2;
        bit seen = 1'b0;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_beat(d1, 8'h03, 19'h300, 8'h11, 1'b0);
        repeat (40) begin
            @(negedge clk);
            if (z_m_vld) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL tmo0_hold: got z_m_vld seen=%b required 0", seen);
        else passes++;
        send_beat(d2, 8'h0C, 19'h302, 8'h11, 1'b1);
        checks++;
        if (z_m_vld !== 1'b1 || z_m_stb !== 8'h0F || z_m_lst !== 1'b1 || z_m_adr !== 19'h300 ||
            z_m_dat[31:0] !== {d2[31:16], d1[15:0]})
            $display("[TB] FAIL tmo0_lst: got vld=%b stb=%h lst=%b adr=%h dat=%h required 1/0f/1/00300/%h",
                     z_m_vld, z_m_stb, z_m_lst, z_m_adr, z_m_dat[31:0], {d2[31:16], d1[15:0]});
        else passes++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [DO-1:0] da, db;
        bit stable = 1'b1;
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        m_rdy = 1'b0;
        send_beat(da, 8'hFF, 19'h400, 8'h33, 1'b0);
        present(db, 8'hFF, 19'h408, 8'h33, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!(m_vld === 1'b1 && m_dat === da && m_stb === 8'hFF && m_adr === 19'h400 && s_rdy === 1'b0))
                stable = 1'b0;
            step();
        end
        checks++;
        if (stable !== 1'b1) $display("[TB] FAIL bp_hold: got stable=%b required 1", stable);
        else passes++;
        m_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (s_rdy !== 1'b1 || m_vld !== 1'b1) $display("[TB] FAIL bp_release: got s_rdy=%b m_vld=%b required 1/1", s_rdy, m_vld);
        else passes++;
        step();
        s_vld = 1'b0;
        checks++;
        if (m_vld !== 1'b1 || m_dat !== db || m_adr !== 19'h408)
            $display("[TB] FAIL bp_next: got vld=%b adr=%h dat=%h required 1/00408/%h", m_vld, m_adr, m_dat, db);
        else passes++;
        step();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        send_beat({$urandom, $urandom}, 8'h0F, 19'h500, 8'h11, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_vld !== 1'b0 || s_rdy !== 1'b1 || m_stb !== 8'h00)
            $display("[TB] FAIL rst_mid: got m_vld=%b s_rdy=%b stb=%h required 0/1/00", m_vld, s_rdy, m_stb);
        else passes++;
        step();
        repeat (40) begin
            @(negedge clk);
            if (m_vld) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL rst_stale: got stale beat seen=%b required 0", seen);
        else passes++;
    endtask

    task automatic test_random();
        localparam int N = 200;
        beat_t beats[$];
        beat_t exp_q[$];
        beat_t b, g;
        bit open = 1'b0;
        bit acc;
        int idx = 0, got = 0, cyc = 0, gap = 0;
        for (int k = 0; k < N; k++) begin
            int mode = $urandom_range(0, 6);
            b.dat = {$urandom, $urandom};
            b.adr = 19'h100 + 19'(8 * $urandom_range(0, 2)) + 19'($urandom_range(0, 7));
            b.sb  = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'h11;
            b.lst = ($urandom_range(0, 9) == 0);
            case (mode)
                0:       b.stb = 8'hFF;
                1:       b.stb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h01 << $urandom_range(0, 7);
                2, 3:    b.stb = 8'h03 << (2 * $urandom_range(0, 3));
                4:       b.stb = 8'h01 << $urandom_range(0, 7);
                default: b.stb = 8'($urandom);
            endcase
            beats.push_back(b);
        end
        // Greedy grouping: a beat joins the open group only if same word, same sideband,
        // disjoint lanes and the group has not seen last; full or last closes a group.
        foreach (beats[k]) begin
            b = beats[k];
            if (open && (b.adr >> 3) == (g.adr >> 3) && b.sb == g.sb && (b.stb & g.stb) == 8'h00 && !g.lst) begin
                for (int i = 0; i < 8; i++) if (b.stb[i]) g.dat[8*i +: 8] = b.dat[8*i +: 8];
                g.stb = g.stb | b.stb;
                g.lst = g.lst | b.lst;
            end else begin
                if (open) exp_q.push_back(g);
                g = b;
                g.adr = (b.adr >> 3) << 3;
                open = 1'b1;
            end
            if (g.stb == 8'hFF || g.lst) begin
                exp_q.push_back(g);
                open = 1'b0;
            end
        end
        if (open) exp_q.push_back(g);

        while (got < exp_q.size() && cyc < 5000) begin
            if (gap > 0) begin
                s_vld = 1'b0;
                gap--;
            end else if (idx < N) begin
                present(beats[idx].dat, beats[idx].stb, beats[idx].adr, beats[idx].sb, beats[idx].lst);
            end else begin
                s_vld = 1'b0;
            end
            m_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_vld && m_rdy) begin
                g = exp_q[got];
                checks++;
                if (m_dat !== g.dat || m_stb !== g.stb || m_adr !== g.adr || m_sb !== g.sb || m_lst !== g.lst)
                    $display("[TB] FAIL rand_beat %0d: got dat=%h stb=%h adr=%h sb=%h lst=%b required dat=%h stb=%h adr=%h sb=%h lst=%b",
                             got, m_dat, m_stb, m_adr, m_sb, m_lst, g.dat, g.stb, g.adr, g.sb, g.lst);
                else passes++;
                got++;
            end
            acc = s_vld && s_rdy;
            step();
            if (acc) begin
                idx++;
                if ($urandom_range(0, 4) == 0) gap = $urandom_range(1, 4);
            end
            cyc++;
        end
        s_vld = 1'b0;
        m_rdy = 1'b1;
        checks++;
        if (got != exp_q.size() || idx != N)
            $display("[TB] FAIL rand_count: got %0d beats out, %0d in; required %0d out, %0d in", got, idx, exp_q.size(), N);
        else passes++;
    endtask

    initial begin
        rst   = 1'b1;
        m_rdy = 1'b1;
        s_vld = 1'b0;
        s_dat = '0;
        s_stb = '0;
        s_adr = '0;
        s_sb  = '0;
        s_lst = 1'b0;
        test_reset();
        test_four_beats();
        test_addr_change();
        test_overlap();
        test_timeout();
        test_timeout_disabled();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
